// File: rtl/fft_pkg.sv
// Shared definitions for the FFT sequencer: controller state encoding,
// size helpers and the bit-reverse used for natural-order unload.
package fft_pkg;

  localparam int unsigned FFT_MAX_LOG2_N = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_COMPUTE,
    ST_DRAIN,
    ST_UNLOAD,
    ST_DONE
  } fft_ctrl_state_t;

  // Width of the stage counter for a given transform order.
  function automatic int unsigned fft_stage_w(input int unsigned log2_n);
    return $clog2(log2_n);
  endfunction

  // Butterflies per stage (N/2).
  function automatic int unsigned fft_half_n(input int unsigned log2_n);
    return 32'd1 << (log2_n - 1);
  endfunction

  // Reverse the low 'width' bits of idx; upper bits of the result are zero.
  function automatic logic [FFT_MAX_LOG2_N-1:0] fft_bitrev(
    input logic [FFT_MAX_LOG2_N-1:0] idx,
    input int unsigned               width
  );
    logic [FFT_MAX_LOG2_N-1:0] rev;
    rev = {<<{idx}};
    return rev >> (FFT_MAX_LOG2_N - width);
  endfunction

endpackage

// File: rtl/fft_issue_pipe.sv
// Butterfly issue tracker: a DEPTH-deep valid shift register whose tail is
// the RAM write enable for the butterfly issued DEPTH cycles earlier.
module fft_issue_pipe #(
  parameter int unsigned DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic issue,
  output logic we
);

  logic [DEPTH-1:0] sr;

  // Shift issues toward the write-enable tap; flush drops anything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr <= '0;
    end else if (flush) begin
      sr <= '0;
    end else begin
      sr <= DEPTH'({sr, issue});
    end
  end

  assign we = sr[DEPTH-1];

endmodule

// File: rtl/fft_controller.sv
// Sequencer for the in-place radix-2 FFT: load N samples, run LOG2_N stages
// of N/2 butterflies with BFLY_LAT drain gaps, then stream results out.
// Build option FFT_BITREV_OUT_EN: unload addresses are bit-reversed so
// results leave in natural frequency order.
module fft_controller
  import fft_pkg::*;
#(
  parameter int unsigned LOG2_N   = 10,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned BFLY_LAT = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       inverse,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_real,
  input  logic [DATA_W-1:0]          in_imag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_real,
  output logic [DATA_W-1:0]          out_imag,
  output logic [$clog2(LOG2_N)-1:0]  stage_cnt,
  output logic [LOG2_N-2:0]          cycle_cnt,
  output logic                       ram_ext_sel,
  output logic [LOG2_N-1:0]          ext_idx,
  output logic                       ram_we,
  input  logic [DATA_W-1:0]          ram_rd_real,
  input  logic [DATA_W-1:0]          ram_rd_imag,
  output logic                       twiddle_conj,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned STAGE_W = fft_stage_w(LOG2_N);
  localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(LOG2_N - 1);
  localparam logic [2:0]         LAST_DRAIN = 3'(BFLY_LAT - 1);

  fft_ctrl_state_t   state;
  logic [LOG2_N-1:0] unld_cnt;
  logic [2:0]        drain_cnt;
  logic              out_first;
  logic [DATA_W-1:0] hold_real;
  logic [DATA_W-1:0] hold_imag;
  logic              issue;
  logic              pipe_flush;
  logic              pipe_we;

  // Map the unload counter to the RAM address presented on ext_idx.
  function automatic logic [LOG2_N-1:0] unload_addr(input logic [LOG2_N-1:0] cnt);
`ifdef FFT_BITREV_OUT_EN
    return LOG2_N'(fft_bitrev(FFT_MAX_LOG2_N'(cnt), LOG2_N));
`else
    return cnt;
`endif
  endfunction

  // Issue every COMPUTE cycle; the pipe empties itself during DRAIN and is
  // only flushed once the compute phase has been left.
  assign issue      = (state == ST_COMPUTE);
  assign pipe_flush = (state != ST_COMPUTE) && (state != ST_DRAIN);

  fft_issue_pipe #(
    .DEPTH (BFLY_LAT)
  ) u_issue_pipe (
    .clk   (clk),
    .rst   (rst),
    .flush (pipe_flush),
    .issue (issue),
    .we    (pipe_we)
  );

  // Load writes happen in the handshake cycle with the host data on the bus;
  // in_ready is only high in LOAD, so in_valid is ignored elsewhere.
  assign ram_we = (in_ready & in_valid) | pipe_we;

  // Read data is passed straight through on the first valid cycle and then
  // held from the capture register until the handshake.
  assign out_real = out_valid ? (out_first ? ram_rd_real : hold_real) : '0;
  assign out_imag = out_valid ? (out_first ? ram_rd_imag : hold_imag) : '0;

  // Main sequencer: state, counters and registered control outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      in_ready     <= 1'b0;
      out_valid    <= 1'b0;
      out_first    <= 1'b0;
      hold_real    <= '0;
      hold_imag    <= '0;
      stage_cnt    <= '0;
      cycle_cnt    <= '0;
      ram_ext_sel  <= 1'b0;
      ext_idx      <= '0;
      unld_cnt     <= '0;
      drain_cnt    <= '0;
      twiddle_conj <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state        <= ST_LOAD;
            twiddle_conj <= inverse;
            busy         <= 1'b1;
            in_ready     <= 1'b1;
            ram_ext_sel  <= 1'b1;
            ext_idx      <= '0;
            stage_cnt    <= '0;
            cycle_cnt    <= '0;
            unld_cnt     <= '0;
            drain_cnt    <= '0;
          end
        end
        ST_LOAD: begin
          if (in_valid) begin
            ext_idx <= ext_idx + 1'b1;
            if (ext_idx == '1) begin
              state       <= ST_COMPUTE;
              in_ready    <= 1'b0;
              ram_ext_sel <= 1'b0;
              stage_cnt   <= '0;
              cycle_cnt   <= '0;
            end
          end
        end
        ST_COMPUTE: begin
          cycle_cnt <= cycle_cnt + 1'b1;
          if (cycle_cnt == '1) begin
            state     <= ST_DRAIN;
            drain_cnt <= '0;
          end
        end
        ST_DRAIN: begin
          drain_cnt <= drain_cnt + 1'b1;
          if (drain_cnt == LAST_DRAIN) begin
            if (stage_cnt < LAST_STAGE) begin
              stage_cnt <= stage_cnt + 1'b1;
              cycle_cnt <= '0;
              state     <= ST_COMPUTE;
            end else begin
              state       <= ST_UNLOAD;
              ram_ext_sel <= 1'b1;
              unld_cnt    <= '0;
              ext_idx     <= unload_addr('0);
              out_valid   <= 1'b0;
            end
          end
        end
        ST_UNLOAD: begin
          if (!out_valid) begin
            // Address phase: read data appears next cycle.
            out_valid <= 1'b1;
            out_first <= 1'b1;
          end else begin
            out_first <= 1'b0;
            if (out_first) begin
              hold_real <= ram_rd_real;
              hold_imag <= ram_rd_imag;
            end
            if (out_ready) begin
              out_valid <= 1'b0;
              unld_cnt  <= unld_cnt + 1'b1;
              ext_idx   <= unload_addr(unld_cnt + 1'b1);
              if (unld_cnt == '1) begin
                state       <= ST_DONE;
                done        <= 1'b1;
                ram_ext_sel <= 1'b0;
                ext_idx     <= '0;
              end
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
